// File: rtl/present_pkg.sv
// present_pkg: shared constants, S-box tables, bit-layer helpers and FSM
// state type for the PRESENT-80 decryptor.
//   BLOCK_W / KEY_W match the encryptor's `size / `key_size (64 / 80).
//   ROUNDS is the number of full rounds; the final round key is K32.
package present_pkg;

  localparam int BLOCK_W = 64;
  localparam int KEY_W   = 80;
  localparam int ROUNDS  = 31;

  localparam logic [3:0] SBOX [16] = '{
    4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
    4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
  };

  localparam logic [3:0] INV_SBOX [16] = '{
    4'h5, 4'hE, 4'hF, 4'h8, 4'hC, 4'h1, 4'h2, 4'hD,
    4'hB, 4'h4, 4'h6, 4'h3, 4'h0, 4'h7, 4'h9, 4'hA
  };

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    KEYGEN = 2'd1,
    WHITEN = 2'd2,
    ROUND  = 2'd3
  } fsm_state_t;

  // Bit i moves to position 16*i mod 63; bit 63 stays put.
  function automatic logic [BLOCK_W-1:0] p_layer(input logic [BLOCK_W-1:0] s);
    logic [BLOCK_W-1:0] r;
    r = '0;
    for (int i = 0; i < 63; i++) begin
      r[6'((16 * i) % 63)] = s[6'(i)];
    end
    r[63] = s[63];
    return r;
  endfunction

  function automatic logic [BLOCK_W-1:0] p_layer_inv(input logic [BLOCK_W-1:0] s);
    logic [BLOCK_W-1:0] r;
    r = '0;
    for (int i = 0; i < 63; i++) begin
      r[6'(i)] = s[6'((16 * i) % 63)];
    end
    r[63] = s[63];
    return r;
  endfunction

  function automatic logic [BLOCK_W-1:0] sbox_layer_inv(input logic [BLOCK_W-1:0] s);
    logic [BLOCK_W-1:0] r;
    r = '0;
    for (int n = 0; n < 16; n++) begin
      r[6'(4 * n) +: 4] = INV_SBOX[s[6'(4 * n) +: 4]];
    end
    return r;
  endfunction

  // Forward key-schedule step producing K(cnt+1) from K(cnt).
  function automatic logic [KEY_W-1:0] ks_fwd(input logic [KEY_W-1:0] k,
                                              input logic [4:0]       cnt);
    logic [KEY_W-1:0] t;
    t         = {k[18:0], k[79:19]};
    t[79:76]  = SBOX[t[79:76]];
    t[19:15]  = t[19:15] ^ cnt;
    return t;
  endfunction

  // Exact inverse of ks_fwd: recovers K(cnt) from K(cnt+1).
  function automatic logic [KEY_W-1:0] ks_inv(input logic [KEY_W-1:0] k,
                                              input logic [4:0]       cnt);
    logic [KEY_W-1:0] t;
    t         = k;
    t[19:15]  = t[19:15] ^ cnt;
    t[79:76]  = INV_SBOX[t[79:76]];
    return {t[60:0], t[79:61]};
  endfunction

endpackage

// File: rtl/present_inv_round.sv
// present_inv_round: one combinational inverse PRESENT round.
//   state      : current cipher state (after round cnt+1 was undone)
//   key_reg    : key register holding K(cnt+1)
//   cnt        : round number being undone (31..1)
//   state_next : invS(invP(state)) ^ K(cnt)
//   key_next   : key register holding K(cnt)
module present_inv_round
  import present_pkg::*;
(
  input  logic [BLOCK_W-1:0] state,
  input  logic [KEY_W-1:0]   key_reg,
  input  logic [4:0]         cnt,
  output logic [BLOCK_W-1:0] state_next,
  output logic [KEY_W-1:0]   key_next
);

  logic [KEY_W-1:0] k_prev;

  assign k_prev     = ks_inv(key_reg, cnt);
  assign key_next   = k_prev;
  assign state_next = sbox_layer_inv(p_layer_inv(state)) ^ k_prev[KEY_W-1:KEY_W-BLOCK_W];

endmodule

// File: rtl/present_decrypt.sv
// present_decrypt: iterative PRESENT-80 block decryptor.
//   clk        : rising-edge clock
//   rst        : asynchronous active-low reset
//   start      : request, sampled only in IDLE (and not while done is high)
//   orig_key   : 80-bit cipher key, latched on accepted start
//   ciphertext : 64-bit block, latched on accepted start
//   plaintext  : result, valid from done until the next accepted start
//   busy       : high in KEYGEN, WHITEN and ROUND
//   done       : one-cycle pulse when plaintext becomes valid
//   dbg_state  : current FSM state
// Handshake: a start is taken on the rising edge where state is IDLE, done is
// low and start is high; it is dropped otherwise (no queueing). Completion is
// signalled by a single-cycle done pulse with plaintext updated in that cycle.
// Optional macro PRESENT_KEY_CACHE_EN: remembers the last key and its K32 so a
// repeated key skips KEYGEN (32-cycle latency instead of 63).
module present_decrypt
  import present_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [KEY_W-1:0]   orig_key,
  input  logic [BLOCK_W-1:0] ciphertext,
  output logic [BLOCK_W-1:0] plaintext,
  output logic               busy,
  output logic               done,
  output fsm_state_t         dbg_state
);

  fsm_state_t         state_q, state_d;
  logic [KEY_W-1:0]   key_reg, key_d;
  logic [BLOCK_W-1:0] state_reg, blk_d;
  logic [4:0]         cnt, cnt_d;
  logic [BLOCK_W-1:0] pt_d;
  logic               done_d;

  logic [BLOCK_W-1:0] rnd_state;
  logic [KEY_W-1:0]   rnd_key;

`ifdef PRESENT_KEY_CACHE_EN
  logic [KEY_W-1:0] cached_key, cached_key_d;
  logic [KEY_W-1:0] cached_k32, cached_k32_d;
  logic             cache_valid, cache_valid_d;
`endif

  present_inv_round u_inv_round (
    .state      (state_reg),
    .key_reg    (key_reg),
    .cnt        (cnt),
    .state_next (rnd_state),
    .key_next   (rnd_key)
  );

  always_comb begin
    state_d = state_q;
    key_d   = key_reg;
    blk_d   = state_reg;
    cnt_d   = cnt;
    pt_d    = plaintext;
    done_d  = 1'b0;
`ifdef PRESENT_KEY_CACHE_EN
    cached_key_d  = cached_key;
    cached_k32_d  = cached_k32;
    cache_valid_d = cache_valid;
`endif
    case (state_q)
      IDLE: begin
        // While done is high the FSM is still considered to be leaving ROUND.
        if (start && !done) begin
          key_d   = orig_key;
          blk_d   = ciphertext;
          cnt_d   = 5'd1;
          state_d = KEYGEN;
`ifdef PRESENT_KEY_CACHE_EN
          if (cache_valid && (orig_key == cached_key)) begin
            key_d   = cached_k32;
            state_d = WHITEN;
          end else begin
            // The key is recorded now; it only becomes usable once KEYGEN
            // completes and cache_valid is set.
            cached_key_d  = orig_key;
            cache_valid_d = 1'b0;
          end
`endif
        end
      end
      KEYGEN: begin
        key_d = ks_fwd(key_reg, cnt);
        if (cnt == 5'(ROUNDS)) begin
          state_d = WHITEN;
`ifdef PRESENT_KEY_CACHE_EN
          cached_k32_d  = ks_fwd(key_reg, cnt);
          cache_valid_d = 1'b1;
`endif
        end else begin
          cnt_d = cnt + 5'd1;
        end
      end
      WHITEN: begin
        blk_d   = state_reg ^ key_reg[KEY_W-1:KEY_W-BLOCK_W];
        cnt_d   = 5'(ROUNDS);
        state_d = ROUND;
      end
      ROUND: begin
        key_d = rnd_key;
        blk_d = rnd_state;
        if (cnt == 5'd1) begin
          pt_d    = rnd_state;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt - 5'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      key_reg   <= '0;
      state_reg <= '0;
      cnt       <= '0;
      plaintext <= '0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_d;
      key_reg   <= key_d;
      state_reg <= blk_d;
      cnt       <= cnt_d;
      plaintext <= pt_d;
      done      <= done_d;
    end
  end

`ifdef PRESENT_KEY_CACHE_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cached_key  <= '0;
      cached_k32  <= '0;
      cache_valid <= 1'b0;
    end else begin
      cached_key  <= cached_key_d;
      cached_k32  <= cached_k32_d;
      cache_valid <= cache_valid_d;
    end
  end
`endif

  assign busy      = (state_q != IDLE);
  assign dbg_state = state_q;

endmodule
